// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
// Multi-cycle data memory with a fixed number of wait states per access.
// The controller raises STM (store) or LDM (load) while the unit is idle.
// The unit captures the request and stays busy for WAIT+2 cycles. The last
// of those cycles is the done cycle, and a load result is valid on rdata
// during it.
//
// Ports
//   clock  in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   STM    in   store request
//   LDM    in   load request
//   addr   in   [AW-1:0] word address, captured at acceptance
//   wdata  in   [DW-1:0] store data, captured at acceptance
//   rdata  out  [DW-1:0] registered load result, held until the next load
//   busy   out  access in progress (includes the done cycle)
//   done   out  one-cycle completion pulse
//   err    out  one-cycle pulse after an illegal STM+LDM request
// ---------------------------------------------------------------------------
module data_mem_unit #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int WAIT = 2
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          STM,
  input  logic          LDM,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_C = 3'(WAIT);

  state_t        state_r;
  logic [2:0]    cnt_r;
  logic          op_store_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          err_r;
  logic [DW-1:0] rdata_r;

  // Storage is intentionally not reset.
  logic [DW-1:0] mem_r [2**AW];

  logic access_s;
  logic mem_we_s;

  // Access strobe: the last wait-state edge of a BUSY period.
  always_comb begin
    access_s = 1'b0;
    mem_we_s = 1'b0;
    if (state_r == BUSY && cnt_r == WAIT_C) begin
      access_s = 1'b1;
      mem_we_s = op_store_r;
    end else begin
      access_s = 1'b0;
      mem_we_s = 1'b0;
    end
  end

  // Control FSM, captured request, load result and error pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      op_store_r <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (STM ^ LDM) begin
            op_store_r <= STM;
            addr_r     <= addr;
            wdata_r    <= wdata;
            cnt_r      <= 3'd0;
            state_r    <= BUSY;
          end else if (STM && LDM) begin
            // Illegal request: no access is made and the FSM stays idle.
            err_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (access_s) begin
            if (!op_store_r) begin
              rdata_r <= mem_r[addr_r];
            end else begin
              rdata_r <= rdata_r;
            end
            state_r <= DONE;
          end else begin
            // WAIT is at most 7, so the counter stops before wrapping.
            cnt_r <= cnt_r + 3'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Memory write port. A reset forces the state to IDLE, which drops
  // mem_we_s, so an aborted store never commits.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  assign busy  = (state_r != IDLE);
  assign done  = (state_r == DONE);
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
// Directed bench for data_mem_unit. One instance uses WAIT=2 and the other
// uses WAIT=0. Inputs are driven and outputs are sampled on the falling
// edge. "Cycle k" means the interval after rising edge k.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;

  logic       clk;
  logic       rst_n;

  logic       stm_a, ldm_a;
  logic [4:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       busy_a, done_a, err_a;

  logic       stm_b, ldm_b;
  logic [4:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       busy_b, done_b, err_b;

  int pass_cnt  = 0;
  int check_cnt = 0;

  data_mem_unit #(.AW(5), .DW(8), .WAIT(2)) dut_a (
    .clock(clk), .rst(rst_n), .STM(stm_a), .LDM(ldm_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  data_mem_unit #(.AW(5), .DW(8), .WAIT(0)) dut_b (
    .clock(clk), .rst(rst_n), .STM(stm_b), .LDM(ldm_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one request on the WAIT=2 unit. The task is entered on a falling
  // edge and returns on the first falling edge where busy is low.
  task automatic access_a(input logic st, input logic ld, input logic [4:0] a,
                          input logic [7:0] d, input bit scramble,
                          output int nbusy, output int ndone, output int done_at,
                          output logic [7:0] rd, output int errbusy);
    nbusy = 0; ndone = 0; done_at = -1; rd = 8'h00; errbusy = 0;
    stm_a = st; ldm_a = ld; addr_a = a; wdata_a = d;
    @(posedge clk);
    @(negedge clk);
    stm_a = 1'b0; ldm_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy_a) break;
      nbusy++;
      if (err_a) errbusy++;
      if (done_a) begin
        ndone++; done_at = k; rd = rdata_a;
      end
      if (scramble) begin
        addr_a = 5'($urandom); wdata_a = 8'($urandom);
      end
      @(negedge clk);
    end
  endtask

  // Runs one request on the WAIT=0 unit.
  task automatic access_b(input logic st, input logic ld, input logic [4:0] a,
                          input logic [7:0] d,
                          output int nbusy, output int ndone, output int done_at,
                          output logic [7:0] rd);
    nbusy = 0; ndone = 0; done_at = -1; rd = 8'h00;
    stm_b = st; ldm_b = ld; addr_b = a; wdata_b = d;
    @(posedge clk);
    @(negedge clk);
    stm_b = 1'b0; ldm_b = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy_b) break;
      nbusy++;
      if (done_b) begin
        ndone++; done_at = k; rd = rdata_b;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stm_a = 1'b0; ldm_a = 1'b0; addr_a = 5'd0; wdata_a = 8'h00;
    stm_b = 1'b0; ldm_b = 1'b0; addr_b = 5'd0; wdata_b = 8'h00;
    @(negedge clk); @(negedge clk);
    check_cnt++; if (busy_a !== 1'b0) $display("FAIL reset busy_a: got %b expected 0", busy_a); else pass_cnt++;
    check_cnt++; if (done_a !== 1'b0) $display("FAIL reset done_a: got %b expected 0", done_a); else pass_cnt++;
    check_cnt++; if (err_a !== 1'b0) $display("FAIL reset err_a: got %b expected 0", err_a); else pass_cnt++;
    check_cnt++; if (rdata_a !== 8'h00) $display("FAIL reset rdata_a: got %h expected 00", rdata_a); else pass_cnt++;
    check_cnt++; if (busy_b !== 1'b0) $display("FAIL reset busy_b: got %b expected 0", busy_b); else pass_cnt++;
    check_cnt++; if (rdata_b !== 8'h00) $display("FAIL reset rdata_b: got %h expected 00", rdata_b); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  // Store A7 to addr 5, then load it back. The store is accepted at the
  // first edge after reset is released.
  task automatic test_store_load();
    int nb, nd, da, eb;
    logic [7:0] rd;
    access_a(1'b1, 1'b0, 5'd5, 8'hA7, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (nb !== 4) $display("FAIL store busy_cycles: got %0d expected 4", nb); else pass_cnt++;
    check_cnt++; if (nd !== 1) $display("FAIL store done_count: got %0d expected 1", nd); else pass_cnt++;
    check_cnt++; if (da !== 3) $display("FAIL store done_cycle: got %0d expected 3", da); else pass_cnt++;
    check_cnt++; if (eb !== 0) $display("FAIL store err_while_busy: got %0d expected 0", eb); else pass_cnt++;
    check_cnt++; if (rdata_a !== 8'h00) $display("FAIL store rdata_untouched: got %h expected 00", rdata_a); else pass_cnt++;
    access_a(1'b0, 1'b1, 5'd5, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (nb !== 4) $display("FAIL load busy_cycles: got %0d expected 4", nb); else pass_cnt++;
    check_cnt++; if (da !== 3) $display("FAIL load done_cycle: got %0d expected 3", da); else pass_cnt++;
    check_cnt++; if (rd !== 8'hA7) $display("FAIL load rdata_at_done: got %h expected a7", rd); else pass_cnt++;
    check_cnt++; if (rdata_a !== 8'hA7) $display("FAIL load rdata_hold: got %h expected a7", rdata_a); else pass_cnt++;
  endtask

  task automatic test_illegal();
    int nb, nd, da, eb;
    logic [7:0] rd;
    stm_a = 1'b1; ldm_a = 1'b1; addr_a = 5'd5; wdata_a = 8'h11;
    @(posedge clk); @(negedge clk);
    stm_a = 1'b0; ldm_a = 1'b0;
    check_cnt++; if (err_a !== 1'b1) $display("FAIL illegal err_pulse: got %b expected 1", err_a); else pass_cnt++;
    check_cnt++; if (busy_a !== 1'b0) $display("FAIL illegal busy: got %b expected 0", busy_a); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (err_a !== 1'b0) $display("FAIL illegal err_one_cycle: got %b expected 0", err_a); else pass_cnt++;
    check_cnt++; if (busy_a !== 1'b0) $display("FAIL illegal busy_after: got %b expected 0", busy_a); else pass_cnt++;
    access_a(1'b0, 1'b1, 5'd5, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'hA7) $display("FAIL illegal mem_unchanged: got %h expected a7", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nb, nd, da, eb;
    logic [7:0] rd;
    int nacc, first, second, ndone;
    logic prev;
    nacc = 0; first = -1; second = -1; ndone = 0; prev = 1'b0;
    stm_a = 1'b1; addr_a = 5'd7; wdata_a = 8'h42;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (busy_a && !prev) begin
        nacc++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (done_a) ndone++;
      prev = busy_a;
      if (k == 9) stm_a = 1'b0;
    end
    check_cnt++; if (nacc !== 2) $display("FAIL b2b acceptances: got %0d expected 2", nacc); else pass_cnt++;
    check_cnt++; if (first !== 0) $display("FAIL b2b first_accept: got %0d expected 0", first); else pass_cnt++;
    check_cnt++; if (second - first !== 5) $display("FAIL b2b spacing: got %0d expected 5", second - first); else pass_cnt++;
    check_cnt++; if (ndone !== 2) $display("FAIL b2b done_count: got %0d expected 2", ndone); else pass_cnt++;
    access_a(1'b0, 1'b1, 5'd7, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'h42) $display("FAIL b2b stored_value: got %h expected 42", rd); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int nb, nd, da, eb;
    logic [7:0] rd;
    access_a(1'b1, 1'b0, 5'd9, 8'h3C, 1'b0, nb, nd, da, rd, eb);
    access_a(1'b0, 1'b1, 5'd9, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'h3C) $display("FAIL abort preload: got %h expected 3c", rd); else pass_cnt++;
    stm_a = 1'b1; addr_a = 5'd9; wdata_a = 8'hFF;
    @(posedge clk); @(negedge clk);
    stm_a = 1'b0;
    check_cnt++; if (busy_a !== 1'b1) $display("FAIL abort busy_before: got %b expected 1", busy_a); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cnt++; if (busy_a !== 1'b0) $display("FAIL abort busy_in_reset: got %b expected 0", busy_a); else pass_cnt++;
    check_cnt++; if (rdata_a !== 8'h00) $display("FAIL abort rdata_cleared: got %h expected 00", rdata_a); else pass_cnt++;
    check_cnt++; if (done_a !== 1'b0) $display("FAIL abort done_in_reset: got %b expected 0", done_a); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    access_a(1'b0, 1'b1, 5'd9, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (nb !== 4) $display("FAIL abort first_accept: got %0d busy cycles expected 4", nb); else pass_cnt++;
    check_cnt++; if (rd !== 8'h3C) $display("FAIL abort no_commit: got %h expected 3c", rd); else pass_cnt++;
  endtask

  task automatic test_wait0();
    int nb, nd, da;
    logic [7:0] rd;
    access_b(1'b1, 1'b0, 5'd2, 8'h9D, nb, nd, da, rd);
    check_cnt++; if (nb !== 2) $display("FAIL wait0 store_busy: got %0d expected 2", nb); else pass_cnt++;
    check_cnt++; if (da !== 1) $display("FAIL wait0 store_done_cycle: got %0d expected 1", da); else pass_cnt++;
    access_b(1'b0, 1'b1, 5'd2, 8'h00, nb, nd, da, rd);
    check_cnt++; if (nb !== 2) $display("FAIL wait0 load_busy: got %0d expected 2", nb); else pass_cnt++;
    check_cnt++; if (nd !== 1) $display("FAIL wait0 load_done_count: got %0d expected 1", nd); else pass_cnt++;
    check_cnt++; if (da !== 1) $display("FAIL wait0 load_done_cycle: got %0d expected 1", da); else pass_cnt++;
    check_cnt++; if (rd !== 8'h9D) $display("FAIL wait0 rdata: got %h expected 9d", rd); else pass_cnt++;
  endtask

  task automatic test_input_scramble();
    int nb, nd, da, eb;
    logic [7:0] rd;
    access_a(1'b1, 1'b0, 5'd13, 8'h11, 1'b0, nb, nd, da, rd, eb);
    access_a(1'b1, 1'b0, 5'd12, 8'h6E, 1'b1, nb, nd, da, rd, eb);
    access_a(1'b0, 1'b1, 5'd12, 8'h00, 1'b1, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'h6E) $display("FAIL scramble captured_value: got %h expected 6e", rd); else pass_cnt++;
    access_a(1'b0, 1'b1, 5'd13, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'h11) $display("FAIL scramble neighbour_intact: got %h expected 11", rd); else pass_cnt++;
    access_a(1'b0, 1'b1, 5'd5, 8'h00, 1'b0, nb, nd, da, rd, eb);
    check_cnt++; if (rd !== 8'hA7) $display("FAIL scramble addr5_intact: got %h expected a7", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    test_input_scramble();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule
